// File: rtl/nes_io_pkg.sv
// Shared NES I/O definitions: joypad vector layout, Four Score signatures and
// per-player button conditioning.
package nes_io_pkg;

    localparam int unsigned JP_VEC_W    = 10;

    localparam int unsigned BTN_A       = 0;
    localparam int unsigned BTN_B       = 1;
    localparam int unsigned BTN_SELECT  = 2;
    localparam int unsigned BTN_START   = 3;
    localparam int unsigned BTN_UP      = 4;
    localparam int unsigned BTN_DOWN    = 5;
    localparam int unsigned BTN_LEFT    = 6;
    localparam int unsigned BTN_RIGHT   = 7;
    localparam int unsigned BTN_TURBO_A = 8;
    localparam int unsigned BTN_TURBO_B = 9;

    localparam logic [7:0] SIG_4016 = 8'h10;
    localparam logic [7:0] SIG_4017 = 8'h20;

    // Signatures are defined as written in the Four Score docs, i.e. sent MSB first.
    function automatic logic [7:0] sig_serial_order(input logic [7:0] sig);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = sig[7-i];
        end
        return r;
    endfunction

    function automatic logic [7:0] condition_player(input logic [JP_VEC_W-1:0] v,
                                                    input logic phase);
        logic [7:0] c;
        c        = v[7:0];
        c[BTN_A] = v[BTN_A] | (v[BTN_TURBO_A] & phase);
        c[BTN_B] = v[BTN_B] | (v[BTN_TURBO_B] & phase);
        if (v[BTN_UP] && v[BTN_DOWN]) begin
            c[BTN_UP]   = 1'b0;
            c[BTN_DOWN] = 1'b0;
        end
        if (v[BTN_LEFT] && v[BTN_RIGHT]) begin
            c[BTN_LEFT]  = 1'b0;
            c[BTN_RIGHT] = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/jp_serial_port_if.sv
// CPU-side controller-port bus: $4016 strobe write and $4016/$4017 serial reads.
interface jp_serial_port_if;
    logic       enable;
    logic       strobe_wr;
    logic       strobe_data;
    logic [1:0] rd_en;
    logic [1:0] rd_data;

    modport master (output enable, strobe_wr, strobe_data, rd_en, input rd_data);
    modport slave  (input enable, strobe_wr, strobe_data, rd_en, output rd_data);
endinterface

// File: rtl/jp_shift_chan.sv
// One serial controller channel: parallel-load shift register with a saturating
// bit counter; reads past the end return 1.
module jp_shift_chan #(
    parameter int unsigned CH_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [CH_BITS-1:0] load_data,
    input  logic               shift,
    output logic               rd_data
);

    localparam logic [4:0] CNT_END = 5'(CH_BITS);

    logic [CH_BITS-1:0] sr;
    logic [4:0]         cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= CNT_END;
        end else if (load) begin
            sr  <= load_data;
            cnt <= '0;
        end else if (shift && (cnt < CNT_END)) begin
            sr  <= sr >> 1;
            cnt <= cnt + 5'd1;
        end
    end

    assign rd_data = (cnt == CNT_END) ? 1'b1 : sr[0];

endmodule

// File: rtl/jp_serial_port.sv
// NES controller-port emulator: strobe register, turbo divider, button
// conditioning and $4016/$4017 load images feeding two serial channels.
module jp_serial_port
    import nes_io_pkg::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned VEC_W     = JP_VEC_W,
    parameter int unsigned TURBO_DIV = 29830
) (
    input  logic                     i_cpu_clk,
    input  logic                     i_rstn_sync_cpu,
    input  logic [N_PORTS*VEC_W-1:0] i_jp_vector,
    jp_serial_port_if.slave          bus,
    output logic                     o_turbo_phase
);

    localparam int unsigned CH_BITS = (N_PORTS == 4) ? 24 : 8;
    localparam int unsigned TW      = $clog2(TURBO_DIV);

    logic [TW-1:0] turbo_cnt;
    logic          turbo_phase;
    logic          strobe;
    logic          strobe_wr_en;
    logic          load;
    logic [1:0]    shift;
    logic [7:0]    p_cond [N_PORTS];
    logic [CH_BITS-1:0] img0;
    logic [CH_BITS-1:0] img1;

    always_ff @(posedge i_cpu_clk or negedge i_rstn_sync_cpu) begin
        if (!i_rstn_sync_cpu) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt   <= turbo_cnt + 1'b1;
        end
    end

    assign o_turbo_phase = turbo_phase;

    assign strobe_wr_en = bus.strobe_wr & bus.enable;

    always_ff @(posedge i_cpu_clk or negedge i_rstn_sync_cpu) begin
        if (!i_rstn_sync_cpu) begin
            strobe <= 1'b0;
        end else if (strobe_wr_en) begin
            strobe <= bus.strobe_data;
        end
    end

    // A strobe write reloads even when it drops the strobe; load outranks shift in the channel.
    assign load  = strobe_wr_en | strobe;
    assign shift = bus.rd_en & {2{bus.enable & ~strobe}};

    for (genvar p = 0; p < N_PORTS; p++) begin : g_player
        assign p_cond[p] = condition_player(i_jp_vector[p*VEC_W +: VEC_W], turbo_phase);
    end

    if (N_PORTS == 4) begin : g_four_score
        assign img0 = {sig_serial_order(SIG_4016), p_cond[2], p_cond[0]};
        assign img1 = {sig_serial_order(SIG_4017), p_cond[3], p_cond[1]};
    end else begin : g_standard
        assign img0 = p_cond[0];
        assign img1 = p_cond[1];
    end

    jp_shift_chan #(.CH_BITS(CH_BITS)) u_ch0 (
        .clk       (i_cpu_clk),
        .rst_n     (i_rstn_sync_cpu),
        .load      (load),
        .load_data (img0),
        .shift     (shift[0]),
        .rd_data   (bus.rd_data[0])
    );

    jp_shift_chan #(.CH_BITS(CH_BITS)) u_ch1 (
        .clk       (i_cpu_clk),
        .rst_n     (i_rstn_sync_cpu),
        .load      (load),
        .load_data (img1),
        .shift     (shift[1]),
        .rd_data   (bus.rd_data[1])
    );

endmodule
